riscv_wb_merge: RTL and testbench

Writeback merge stage for the RISC-V core. It takes result streams from the exec unit, the LSU and the mul/div unit and drives the single register-file write port, one write per cycle. When sources collide, program order is preserved by an in-order pending FIFO. It also raises issue stalls, or forwards pending values, for operands whose producer has not yet been written back.

---
 rtl/riscv_wb_merge_if.sv | 55 +++++
 rtl/riscv_wb_merge.sv | 170 +++++++++++++++++
 tb/tb_riscv_wb_merge.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/riscv_wb_merge_if.sv
// Bundle of result streams, issue operand indices and register-file write
// port for the writeback merge stage. WB_FORWARD_EN adds the forwarding ports.
interface riscv_wb_merge_if;
  // A result is valid in the cycle its idx is non-zero; there is no ready.
  // Backpressure is only indirect: issue must hold while stall_o is high.
  logic [4:0]  exec_wb_idx_i;
  logic [31:0] exec_wb_value_i;
  logic [4:0]  lsu_wb_idx_i;
  logic [31:0] lsu_wb_value_i;
  logic [4:0]  muldiv_wb_idx_i;
  logic [31:0] muldiv_wb_value_i;
  logic        muldiv_wb_squash_i;
  logic [4:0]  issue_ra_idx_i;
  logic [4:0]  issue_rb_idx_i;
  logic [4:0]  rf_wr_idx_o;
  logic [31:0] rf_wr_value_o;
  logic        stall_o;
  logic        overflow_o;
`ifdef WB_FORWARD_EN
  logic        fwd_ra_valid_o;
  logic [31:0] fwd_ra_value_o;
  logic        fwd_rb_valid_o;
  logic [31:0] fwd_rb_value_o;

  modport slave (
    input  exec_wb_idx_i, exec_wb_value_i, lsu_wb_idx_i, lsu_wb_value_i,
    input  muldiv_wb_idx_i, muldiv_wb_value_i, muldiv_wb_squash_i,
    input  issue_ra_idx_i, issue_rb_idx_i,
    output rf_wr_idx_o, rf_wr_value_o, stall_o, overflow_o,
    output fwd_ra_valid_o, fwd_ra_value_o, fwd_rb_valid_o, fwd_rb_value_o
  );

  modport master (
    output exec_wb_idx_i, exec_wb_value_i, lsu_wb_idx_i, lsu_wb_value_i,
    output muldiv_wb_idx_i, muldiv_wb_value_i, muldiv_wb_squash_i,
    output issue_ra_idx_i, issue_rb_idx_i,
    input  rf_wr_idx_o, rf_wr_value_o, stall_o, overflow_o,
    input  fwd_ra_valid_o, fwd_ra_value_o, fwd_rb_valid_o, fwd_rb_value_o
  );
`else
  modport slave (
    input  exec_wb_idx_i, exec_wb_value_i, lsu_wb_idx_i, lsu_wb_value_i,
    input  muldiv_wb_idx_i, muldiv_wb_value_i, muldiv_wb_squash_i,
    input  issue_ra_idx_i, issue_rb_idx_i,
    output rf_wr_idx_o, rf_wr_value_o, stall_o, overflow_o
  );

  modport master (
    output exec_wb_idx_i, exec_wb_value_i, lsu_wb_idx_i, lsu_wb_value_i,
    output muldiv_wb_idx_i, muldiv_wb_value_i, muldiv_wb_squash_i,
    output issue_ra_idx_i, issue_rb_idx_i,
    input  rf_wr_idx_o, rf_wr_value_o, stall_o, overflow_o
  );
`endif
endinterface

// File: rtl/riscv_wb_merge.sv
// Writeback merge: muxes exec/LSU/muldiv results onto one RF write port in
// program order via a pending FIFO. Optional forwarding under WB_FORWARD_EN.
module riscv_wb_merge #(
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  riscv_wb_merge_if.slave   wb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] value;
  } wb_ent_t;

  wb_ent_t        mem_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [4:0]     out_idx_q, out_idx_d;
  logic [31:0]    out_val_q, out_val_d;
  logic           ovf_q, ovf_d;

  wb_ent_t        src [3];
  logic [2:0]     src_act;
  logic [2:0]     taken;
  wb_ent_t        push_ent [3];
  logic [1:0]     n_push;
  logic [1:0]     n_acc;
  logic           pop;
  logic [CW-1:0]  free_cnt;
  logic           occ_stall;

  // Index 0 is the oldest source within a cycle.
  always_comb begin
    src[0]     = {wb.muldiv_wb_idx_i, wb.muldiv_wb_value_i};
    src[1]     = {wb.lsu_wb_idx_i, wb.lsu_wb_value_i};
    src[2]     = {wb.exec_wb_idx_i, wb.exec_wb_value_i};
    src_act[0] = (wb.muldiv_wb_idx_i != 5'd0) && !wb.muldiv_wb_squash_i;
    src_act[1] = (wb.lsu_wb_idx_i != 5'd0);
    src_act[2] = (wb.exec_wb_idx_i != 5'd0);
  end

  always_comb begin
    pop       = (count_q != '0);
    free_cnt  = CW'(DEPTH) - count_q + CW'(pop);
    out_idx_d = 5'd0;
    out_val_d = out_val_q;
    taken     = 3'b000;
    n_push    = 2'd0;
    n_acc     = 2'd0;
    ovf_d     = ovf_q;
    for (int k = 0; k < 3; k++) begin
      push_ent[k] = '0;
    end

    // A non-empty FIFO always owns the write port so older results drain first.
    if (pop) begin
      out_idx_d = mem_q[rd_ptr_q].idx;
      out_val_d = mem_q[rd_ptr_q].value;
    end else begin
      for (int s = 0; s < 3; s++) begin
        if (src_act[s] && (taken == 3'b000)) begin
          taken[s]  = 1'b1;
          out_idx_d = src[s].idx;
          out_val_d = src[s].value;
        end
      end
    end

    for (int s = 0; s < 3; s++) begin
      if (src_act[s] && !taken[s]) begin
        push_ent[n_push] = src[s];
        n_push           = n_push + 2'd1;
      end
    end

    // Pushes beyond the free space are dropped, youngest first.
    if (CW'(n_push) > free_cnt) begin
      n_acc = free_cnt[1:0];
      ovf_d = 1'b1;
    end else begin
      n_acc = n_push;
    end

    count_d  = count_q - CW'(pop) + CW'(n_acc);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(n_acc);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      out_idx_q <= 5'd0;
      out_val_q <= 32'd0;
      ovf_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      out_idx_q <= out_idx_d;
      out_val_q <= out_val_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < n_acc) begin
        mem_q[wr_ptr_q + PW'(k)] <= push_ent[k];
      end
    end
  end

  assign occ_stall = (free_cnt < CW'(3));

  // Walk the FIFO head to tail after the output register so the youngest match wins.
  logic        ra_hit, rb_hit;
`ifdef WB_FORWARD_EN
  logic [31:0] ra_val, rb_val;
`endif

  always_comb begin
    ra_hit = (wb.issue_ra_idx_i != 5'd0) && (out_idx_q == wb.issue_ra_idx_i);
    rb_hit = (wb.issue_rb_idx_i != 5'd0) && (out_idx_q == wb.issue_rb_idx_i);
`ifdef WB_FORWARD_EN
    ra_val = out_val_q;
    rb_val = out_val_q;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        if ((wb.issue_ra_idx_i != 5'd0) &&
            (mem_q[rd_ptr_q + PW'(k)].idx == wb.issue_ra_idx_i)) begin
          ra_hit = 1'b1;
`ifdef WB_FORWARD_EN
          ra_val = mem_q[rd_ptr_q + PW'(k)].value;
`endif
        end
        if ((wb.issue_rb_idx_i != 5'd0) &&
            (mem_q[rd_ptr_q + PW'(k)].idx == wb.issue_rb_idx_i)) begin
          rb_hit = 1'b1;
`ifdef WB_FORWARD_EN
          rb_val = mem_q[rd_ptr_q + PW'(k)].value;
`endif
        end
      end
    end
  end

  assign wb.rf_wr_idx_o   = out_idx_q;
  assign wb.rf_wr_value_o = out_val_q;
  assign wb.overflow_o    = ovf_q;

`ifdef WB_FORWARD_EN
  assign wb.stall_o        = occ_stall;
  assign wb.fwd_ra_valid_o = ra_hit;
  assign wb.fwd_ra_value_o = ra_hit ? ra_val : 32'd0;
  assign wb.fwd_rb_valid_o = rb_hit;
  assign wb.fwd_rb_value_o = rb_hit ? rb_val : 32'd0;
`else
  assign wb.stall_o = occ_stall | ra_hit | rb_hit;
`endif

endmodule

// File: tb/tb_riscv_wb_merge.sv
// Directed bench for riscv_wb_merge: a per-cycle vector table plus a
// hand-written mid-operation reset sequence.
module tb_riscv_wb_merge;

  logic clk;
  logic rst_n;

  riscv_wb_merge_if wb ();

  riscv_wb_merge #(.DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .wb    (wb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  md_idx;
    logic [31:0] md_val;
    logic        md_sq;
    logic [4:0]  lsu_idx;
    logic [31:0] lsu_val;
    logic [4:0]  ex_idx;
    logic [31:0] ex_val;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  exp_idx;
    logic [31:0] exp_val;
    logic        exp_occ;
    logic        exp_haz;
    logic        exp_ovf;
    logic        exp_fa;
    logic [31:0] exp_fa_val;
    logic        exp_fb;
    logic [31:0] exp_fb_val;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wb.muldiv_wb_idx_i    = v.md_idx;
    wb.muldiv_wb_value_i  = v.md_val;
    wb.muldiv_wb_squash_i = v.md_sq;
    wb.lsu_wb_idx_i       = v.lsu_idx;
    wb.lsu_wb_value_i     = v.lsu_val;
    wb.exec_wb_idx_i      = v.ex_idx;
    wb.exec_wb_value_i    = v.ex_val;
    wb.issue_ra_idx_i     = v.ra;
    wb.issue_rb_idx_i     = v.rb;
  endtask

  task automatic drive_idle();
    vec_t z;
    z = '{default: '0};
    drive(z);
  endtask

  task automatic apply_vec(input int i);
    logic exp_stall;
    @(negedge clk);
    drive(vecs[i]);
    @(posedge clk);
    #1;
`ifdef WB_FORWARD_EN
    exp_stall = vecs[i].exp_occ;
`else
    exp_stall = vecs[i].exp_occ | vecs[i].exp_haz;
`endif
    check($sformatf("v%0d rf_wr_idx", i), 32'(wb.rf_wr_idx_o), 32'(vecs[i].exp_idx));
    check($sformatf("v%0d rf_wr_value", i), wb.rf_wr_value_o, vecs[i].exp_val);
    check($sformatf("v%0d stall", i), 32'(wb.stall_o), 32'(exp_stall));
    check($sformatf("v%0d overflow", i), 32'(wb.overflow_o), 32'(vecs[i].exp_ovf));
`ifdef WB_FORWARD_EN
    check($sformatf("v%0d fwd_ra_valid", i), 32'(wb.fwd_ra_valid_o), 32'(vecs[i].exp_fa));
    check($sformatf("v%0d fwd_rb_valid", i), 32'(wb.fwd_rb_valid_o), 32'(vecs[i].exp_fb));
    if (vecs[i].exp_fa) check($sformatf("v%0d fwd_ra_value", i), wb.fwd_ra_value_o, vecs[i].exp_fa_val);
    if (vecs[i].exp_fb) check($sformatf("v%0d fwd_rb_value", i), wb.fwd_rb_value_o, vecs[i].exp_fb_val);
`endif
  endtask

  initial begin
    // md(idx,val,sq) lsu(idx,val) ex(idx,val) ra rb | idx val occ haz ovf fa faval fb fbval
    vecs[0]  = '{0,0,0,  0,0,      5,'h11,  0,0,  5,'h11,  0,0,0, 0,0,0,0};
    vecs[1]  = '{0,0,0,  0,0,      0,0,     0,0,  0,'h11,  0,0,0, 0,0,0,0};
    vecs[2]  = '{3,'hA,0, 4,'hB,   6,'hC,   0,0,  3,'hA,   0,0,0, 0,0,0,0};
    vecs[3]  = '{0,0,0,  0,0,      0,0,     0,0,  4,'hB,   0,0,0, 0,0,0,0};
    vecs[4]  = '{0,0,0,  0,0,      0,0,     0,0,  6,'hC,   0,0,0, 0,0,0,0};
    vecs[5]  = '{0,0,0,  0,0,      0,0,     0,0,  0,'hC,   0,0,0, 0,0,0,0};
    vecs[6]  = '{7,1,0,  0,0,      7,2,     7,0,  7,1,     0,1,0, 1,2,0,0};
    vecs[7]  = '{0,0,0,  0,0,      0,0,     7,0,  7,2,     0,1,0, 1,2,0,0};
    vecs[8]  = '{0,0,0,  0,0,      0,0,     7,0,  0,2,     0,0,0, 0,0,0,0};
    vecs[9]  = '{9,'h99,1, 0,0,    0,0,     0,0,  0,2,     0,0,0, 0,0,0,0};
    vecs[10] = '{9,'h99,1, 0,0,    1,5,     0,0,  1,5,     0,0,0, 0,0,0,0};
    vecs[11] = '{0,0,0,  0,0,      0,0,     0,0,  0,5,     0,0,0, 0,0,0,0};
    vecs[12] = '{0,0,0,  8,'h88,   9,'h99,  0,9,  8,'h88,  0,1,0, 0,0,1,'h99};
    vecs[13] = '{0,0,0,  0,0,      0,0,     0,0,  9,'h99,  0,0,0, 0,0,0,0};
    vecs[14] = '{0,0,0,  0,0,      0,0,     0,0,  0,'h99,  0,0,0, 0,0,0,0};
    vecs[15] = '{1,'h101,0, 2,'h102, 3,'h103, 0,0, 1,'h101, 0,0,0, 0,0,0,0};
    vecs[16] = '{4,'h104,0, 5,'h105, 6,'h106, 0,0, 2,'h102, 1,0,0, 0,0,0,0};
    vecs[17] = '{10,'h110,0, 11,'h111, 12,'h112, 0,0, 3,'h103, 1,0,1, 0,0,0,0};
    vecs[18] = '{0,0,0,  0,0,      0,0,     0,0,  4,'h104, 1,0,1, 0,0,0,0};
    vecs[19] = '{0,0,0,  0,0,      0,0,     0,0,  5,'h105, 0,0,1, 0,0,0,0};
    vecs[20] = '{0,0,0,  0,0,      0,0,     0,0,  6,'h106, 0,0,1, 0,0,0,0};
    vecs[21] = '{0,0,0,  0,0,      0,0,     0,0,  10,'h110, 0,0,1, 0,0,0,0};
    vecs[22] = '{0,0,0,  0,0,      0,0,     0,0,  0,'h110, 0,0,1, 0,0,0,0};

    // Clock/reset
    rst_n = 1'b0;
    drive_idle();
    #1;
    check("reset rf_wr_idx", 32'(wb.rf_wr_idx_o), 32'd0);
    check("reset rf_wr_value", wb.rf_wr_value_o, 32'd0);
    check("reset stall", 32'(wb.stall_o), 32'd0);
    check("reset overflow", 32'(wb.overflow_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply_vec(i);
    end

    // Mid-operation reset with three entries pending
    @(negedge clk);
    wb.muldiv_wb_idx_i = 5'd1;  wb.muldiv_wb_value_i = 32'h201;
    wb.lsu_wb_idx_i    = 5'd2;  wb.lsu_wb_value_i    = 32'h202;
    wb.exec_wb_idx_i   = 5'd3;  wb.exec_wb_value_i   = 32'h203;
    @(posedge clk);
    #1;
    check("rst_seq first write", 32'(wb.rf_wr_idx_o), 32'd1);
    @(negedge clk);
    drive_idle();
    wb.muldiv_wb_idx_i = 5'd4;  wb.muldiv_wb_value_i = 32'h204;
    wb.exec_wb_idx_i   = 5'd5;  wb.exec_wb_value_i   = 32'h205;
    @(posedge clk);
    #1;
    check("rst_seq second write", 32'(wb.rf_wr_idx_o), 32'd2);
    check("rst_seq occupancy stall", 32'(wb.stall_o), 32'd1);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #1;
    check("rst_seq async rf_wr_idx", 32'(wb.rf_wr_idx_o), 32'd0);
    check("rst_seq async rf_wr_value", wb.rf_wr_value_o, 32'd0);
    check("rst_seq async stall", 32'(wb.stall_o), 32'd0);
    check("rst_seq async overflow", 32'(wb.overflow_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst c%0d rf_wr_idx", c), 32'(wb.rf_wr_idx_o), 32'd0);
      check($sformatf("post_rst c%0d stall", c), 32'(wb.stall_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
